// File: rtl/jogo_pkg.sv
// Shared definitions for the sequence-memory game: FSM state codes, the default
// button count and the one-hot validity check used on accepted presses.
package jogo_pkg;

    localparam int N_BOTOES_PADRAO = 4;

    typedef enum logic [2:0] {
        ESPERA = 3'd0,
        CONTA  = 3'd1,
        DECIDE = 3'd2,
        SOLTA  = 3'd3
    } estado_t;

    // True when exactly one bit is set (upper bits beyond the real width are zero).
    function automatic logic eh_one_hot(input logic [31:0] v);
        eh_one_hot = (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/condicionador_botoes_if.sv
// Button-conditioner bus between the raw buttons/control unit and the game datapath.
// Optional macro CONDICIONADOR_BOTAO_PRESO_EN adds the stuck-button flag botao_preso.
interface condicionador_botoes_if #(
    parameter int N_BOTOES = jogo_pkg::N_BOTOES_PADRAO
);
    logic [N_BOTOES-1:0] botoes;
    logic                habilita;
    logic [N_BOTOES-1:0] jogada;
    logic                jogada_feita;
    logic                jogada_invalida;
    logic [2:0]          db_estado;
`ifdef CONDICIONADOR_BOTAO_PRESO_EN
    logic                botao_preso;

    modport master (
        output botoes, habilita,
        input  jogada, jogada_feita, jogada_invalida, db_estado, botao_preso
    );
    modport slave (
        input  botoes, habilita,
        output jogada, jogada_feita, jogada_invalida, db_estado, botao_preso
    );
`else
    modport master (
        output botoes, habilita,
        input  jogada, jogada_feita, jogada_invalida, db_estado
    );
    modport slave (
        input  botoes, habilita,
        output jogada, jogada_feita, jogada_invalida, db_estado
    );
`endif
endinterface

// File: rtl/sincronizador_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs (buttons, iniciar, jogar).
module sincronizador_2ff #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_r;
    logic [W-1:0] sinc_r;

    // Two-stage capture; the second stage is the only one consumed downstream.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_r <= {W{1'b0}};
            sinc_r <= {W{1'b0}};
        end else begin
            meta_r <= d;
            sinc_r <= meta_r;
        end
    end

    assign q = sinc_r;

endmodule

// File: rtl/condicionador_botoes.sv
// Synchronizes, debounces and validates one-hot button presses, one pulse per press.
// Optional macro CONDICIONADOR_BOTAO_PRESO_EN enables the stuck-button detector.
module condicionador_botoes
    import jogo_pkg::*;
#(
    parameter int N_BOTOES        = N_BOTOES_PADRAO,
    parameter int DEBOUNCE_CICLOS = 1000,
    parameter int PRESO_CICLOS    = 50000000
) (
    input  logic                  clock,
    input  logic                  reset,
    condicionador_botoes_if.slave io
);
    localparam int CW = $clog2(DEBOUNCE_CICLOS + 32'sd1);
    localparam logic [CW-1:0]       CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]       CNT_UM   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]       CNT_FIM  = CW'(DEBOUNCE_CICLOS - 32'sd1);
    localparam logic [CW-1:0]       CNT_MAX  = CW'(DEBOUNCE_CICLOS);
    localparam logic [N_BOTOES-1:0] NENHUM   = {N_BOTOES{1'b0}};

    if (DEBOUNCE_CICLOS < 2) begin : g_chk_debounce
        $error("DEBOUNCE_CICLOS must be at least 2");
    end
    if (PRESO_CICLOS < 1) begin : g_chk_preso
        $error("PRESO_CICLOS must be at least 1");
    end

    logic [N_BOTOES-1:0] sb_s;
    estado_t             estado_r, estado_next_s;
    logic [CW-1:0]       cnt_r, cnt_next_s, cnt_inc_s;
    logic [N_BOTOES-1:0] cand_r, cand_next_s;
    logic [N_BOTOES-1:0] jogada_r, jogada_next_s;
    logic                feita_r, feita_next_s;
    logic                invalida_r, invalida_next_s;

    sincronizador_2ff #(.W(N_BOTOES)) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (io.botoes),
        .q     (sb_s)
    );

    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_UM;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r <= ESPERA;
        end else begin
            estado_r <= estado_next_s;
        end
    end

    // Next-state logic plus the debounce counter and press candidate.
    always_comb begin
        estado_next_s = estado_r;
        cnt_next_s    = cnt_r;
        cand_next_s   = cand_r;
        case (estado_r)
            ESPERA: begin
                if (io.habilita && (sb_s != NENHUM)) begin
                    estado_next_s = CONTA;
                    cand_next_s   = sb_s;
                    cnt_next_s    = CNT_UM;
                end else begin
                    estado_next_s = ESPERA;
                    cnt_next_s    = CNT_ZERO;
                end
            end
            CONTA: begin
                // Any bounce or pattern change abandons the candidate completely.
                if (!io.habilita || (sb_s != cand_r)) begin
                    estado_next_s = ESPERA;
                    cnt_next_s    = CNT_ZERO;
                end else if (cnt_r == CNT_FIM) begin
                    estado_next_s = DECIDE;
                end else begin
                    cnt_next_s = cnt_inc_s;
                end
            end
            DECIDE: begin
                estado_next_s = SOLTA;
                cnt_next_s    = CNT_ZERO;
            end
            SOLTA: begin
                if (sb_s != NENHUM) begin
                    cnt_next_s = CNT_ZERO;
                end else if (cnt_r == CNT_FIM) begin
                    estado_next_s = ESPERA;
                    cnt_next_s    = CNT_ZERO;
                end else begin
                    cnt_next_s = cnt_inc_s;
                end
            end
            default: begin
                estado_next_s = ESPERA;
                cnt_next_s    = CNT_ZERO;
                cand_next_s   = NENHUM;
            end
        endcase
    end

    // Output decode: the verdict is registered on the CONTA->DECIDE edge so the
    // pulse is visible during the DECIDE cycle itself.
    always_comb begin
        jogada_next_s   = jogada_r;
        feita_next_s    = 1'b0;
        invalida_next_s = 1'b0;
        if ((estado_r == CONTA) && (estado_next_s == DECIDE)) begin
            if (eh_one_hot(32'(cand_r))) begin
                jogada_next_s = cand_r;
                feita_next_s  = 1'b1;
            end else begin
                invalida_next_s = 1'b1;
            end
        end else begin
            jogada_next_s = jogada_r;
        end
    end

    // Datapath registers: counter, candidate and the registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r      <= CNT_ZERO;
            cand_r     <= NENHUM;
            jogada_r   <= NENHUM;
            feita_r    <= 1'b0;
            invalida_r <= 1'b0;
        end else begin
            cnt_r      <= cnt_next_s;
            cand_r     <= cand_next_s;
            jogada_r   <= jogada_next_s;
            feita_r    <= feita_next_s;
            invalida_r <= invalida_next_s;
        end
    end

    assign io.jogada          = jogada_r;
    assign io.jogada_feita    = feita_r;
    assign io.jogada_invalida = invalida_r;
    assign io.db_estado       = estado_r;

`ifdef CONDICIONADOR_BOTAO_PRESO_EN
    localparam int PW = $clog2(PRESO_CICLOS + 32'sd1);
    localparam logic [PW-1:0] PRESO_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PRESO_UM   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PRESO_MAX  = PW'(PRESO_CICLOS);

    logic [PW-1:0] preso_cnt_r, preso_cnt_next_s;
    logic          preso_r;

    // Hold counter: runs only while a button is still held after the verdict.
    always_comb begin
        preso_cnt_next_s = preso_cnt_r;
        if (estado_next_s == ESPERA) begin
            preso_cnt_next_s = PRESO_ZERO;
        end else if ((estado_r == SOLTA) && (sb_s != NENHUM) && (preso_cnt_r != PRESO_MAX)) begin
            preso_cnt_next_s = preso_cnt_r + PRESO_UM;
        end else begin
            preso_cnt_next_s = preso_cnt_r;
        end
    end

    // Hold counter and stuck flag registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            preso_cnt_r <= PRESO_ZERO;
            preso_r     <= 1'b0;
        end else begin
            preso_cnt_r <= preso_cnt_next_s;
            preso_r     <= (preso_cnt_next_s == PRESO_MAX);
        end
    end

    assign io.botao_preso = preso_r;
`endif

endmodule

// File: doc/condicionador_botoes.md
Name: condicionador_botoes

Overview:
- Input stage between the raw game buttons and the game datapath/control of the sequence-memory game.
- Synchronizes the 4 asynchronous button lines, debounces them, and validates one-hot presses.
- Each accepted press produces exactly one single-cycle jogada_feita pulse with a stable encoded jogada.
- The next press is accepted only after all buttons have been released and the release is stable.

Parameters:
- N_BOTOES, 4, number of button lines.
- DEBOUNCE_CICLOS, 1000, consecutive identical synchronized samples required to accept a press or a release. Must be ≥2.
- PRESO_CICLOS, 50000000, hold time that flags a stuck button. Used only with the optional feature.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset. The port keeps the codebase name "reset"; the polarity is low-true.
- botoes  in  N_BOTOES  raw button levels, active-high, asynchronous.
- habilita  in  1  control unit allows new presses to be accepted.
- jogada  out  N_BOTOES  last accepted one-hot press. Holds its value until the next valid press.
- jogada_feita  out  1  single-cycle pulse: valid press accepted.
- jogada_invalida  out  1  single-cycle pulse: stable multi-button press rejected.
- db_estado  out  3  FSM state code, for the hexa7seg debug display.

Behaviour:
- Reset (reset=0, asynchronous):
  - sync flops = 0, counter = 0, candidate = 0.
  - jogada = 0, jogada_feita = 0, jogada_invalida = 0.
  - state = ESPERA.
- Synchronizer: 2-FF per line. sb = second stage. Latency from pin to sb is 2 cycles.
- Counter width: clog2(DEBOUNCE_CICLOS+1). The counter saturates and never wraps.
- States and codes:
  - ESPERA (0): idle.
    - If habilita=1 and sb≠0: candidate←sb, cnt←1, go to CONTA.
    - If habilita=0: stay.
  - CONTA (1): debouncing a press.
    - If habilita=0 or sb≠candidate: go to ESPERA, cnt←0. A bounce restarts from scratch.
    - If sb=candidate and cnt=DEBOUNCE_CICLOS-1: go to DECIDE.
    - Otherwise: cnt←cnt+1.
  - DECIDE (2): one cycle.
    - If candidate is one-hot: jogada←candidate and jogada_feita=1 for this cycle.
    - Otherwise: jogada_invalida=1 for this cycle and jogada is unchanged.
    - Then cnt←0, go to SOLTA.
  - SOLTA (3): waiting for release.
    - If sb≠0: cnt←0.
    - Otherwise: cnt←cnt+1.
    - When cnt reaches DEBOUNCE_CICLOS-1 with sb=0: go to ESPERA.
    - habilita is ignored here. A held button can never generate a second pulse.
- Latency: first stable sample at sb to the jogada_feita cycle = DEBOUNCE_CICLOS cycles. Pin to pulse = DEBOUNCE_CICLOS+2 cycles.
- jogada_feita and jogada_invalida are registered, mutually exclusive, and never high for two consecutive cycles.
- Pattern changes during CONTA (e.g. 0001→0011) restart the debounce with the new pattern, through ESPERA.
- Reset asserted mid-press: returns to ESPERA. If the button is still held after reset releases, it is treated as a new press.
- Unused state codes 4–7 recover to ESPERA.

Optional Feature:
- Macro: CONDICIONADOR_BOTAO_PRESO_EN.
- When defined:
  - Adds output botao_preso (1 bit, reset 0).
  - Adds a hold counter that runs in SOLTA while sb≠0 and saturates at PRESO_CICLOS.
  - botao_preso = 1 while the hold counter = PRESO_CICLOS.
  - The hold counter clears on entry to ESPERA or on reset.
- When undefined: no port, no counter. Behaviour is otherwise identical.

Decomposition:
- Shared package (jogo_pkg):
  - state codes ESPERA=3'd0, CONTA=3'd1, DECIDE=3'd2, SOLTA=3'd3.
  - N_BOTOES default constant.
  - one-hot check function.
- One sub-module: sincronizador_2ff. Parameterized width, asynchronous active-low reset. Reusable for iniciar/jogar.

Test Plan (bench uses DEBOUNCE_CICLOS=4, PRESO_CICLOS=20):
- Reset: hold reset=0 with botoes=0100 → all outputs 0, db_estado=0. Release reset with botoes still 0100 → jogada_feita exactly 6 cycles after release, jogada=0100.
- Clean press: botoes=0010 held 30 cycles, habilita=1 → one jogada_feita pulse exactly 6 cycles after the edge, jogada=0010, no further pulses. Release → db_estado returns to 0 after 4 stable zero samples.
- Bounce: botoes toggles 0001/0000 every 2 cycles for 12 cycles, then steady 0001 → no pulse during toggling, one pulse 6 cycles after the steady edge.
- Invalid: botoes=1001 steady → jogada_invalida single pulse, jogada keeps its previous value (0010), no jogada_feita.
- habilita=0 while pressing 1000 → no pulse. Raise habilita with the button still held → pulse after 4 more samples. Drop habilita during SOLTA → release still completes normally.
- With CONDICIONADOR_BOTAO_PRESO_EN: hold 0100 for 40 cycles → botao_preso rises 20 cycles after entering SOLTA and clears once the release completes (ESPERA entry). Without the macro, the bench checks the port is absent and all other responses match.
